// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Bundle of the EX/MEM request side, the dcache side and the
//               status outputs of the memory access controller.
//               master : the controller itself.
//               slave  : the surrounding pipeline / dcache.
// Ports       : dren_in, dwen_in, addr_in, store_in, halt_in, flush  (EX/MEM)
//               dhit, dmemload, dmemREN, dmemWEN, dmemaddr, dmemstore (dcache)
//               stall, load_data, mem_done, halt_out, timeout,
//               protocol_err, access_cnt                             (status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dren_in;
  logic             dwen_in;
  logic [31:0]      addr_in;
  logic [31:0]      store_in;
  logic             halt_in;
  logic             flush;
  logic             dhit;
  logic [31:0]      dmemload;
  logic             dmemREN;
  logic             dmemWEN;
  logic [31:0]      dmemaddr;
  logic [31:0]      dmemstore;
  logic             stall;
  logic [31:0]      load_data;
  logic             mem_done;
  logic             halt_out;
  logic             timeout;
  logic             protocol_err;
  logic [CNT_W-1:0] access_cnt;

  modport master (
    input  dren_in, dwen_in, addr_in, store_in, halt_in, flush, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall, load_data, mem_done,
           halt_out, timeout, protocol_err, access_cnt
  );

  modport slave (
    output dren_in, dwen_in, addr_in, store_in, halt_in, flush, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall, load_data, mem_done,
           halt_out, timeout, protocol_err, access_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Consumer end of the EX/MEM latch. Turns a latched load/store
//               request into a held dcache request, waits for dhit, returns
//               load data to MEM/WB and stalls the pipeline until the access
//               retires. Handles halt, flush and a dhit watchdog.
// Parameters  : MAX_WAIT - ACCESS cycles without dhit before timeout (>= 2)
//               CNT_W    - width of the retired-access counter (must match
//                          the interface instance)
// Ports       : CLK  - clock, rising edge
//               RST  - synchronous reset, active-high
//               bus  - mem_access_ctrl_if.master (request, dcache, status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int MAX_WAIT = 256,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  mem_access_ctrl_if.master   bus
);

  localparam int                    c_WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_ren;
  logic                r_wen;
  logic [31:0]         r_addr;
  logic [31:0]         r_store;
  logic [31:0]         r_load;
  logic                r_mem_done;
  logic                r_halt;
  logic                r_timeout;
  logic                r_flushed;
  logic [c_WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_op;
  logic                w_launch;
  logic                w_discard;

  assign w_op      = bus.dren_in | bus.dwen_in;
  assign w_launch  = (r_state == S_IDLE) && w_op && !bus.flush;
  // A flush in the same cycle as dhit still discards the completion.
  assign w_discard = r_flushed | bus.flush;

  // Stall must rise in the launch cycle itself so EX/MEM holds the op
  // while the request is being latched.
  assign bus.stall        = w_launch || (r_state == S_ACCESS);
  assign bus.protocol_err = w_launch && bus.dren_in && bus.dwen_in;

  assign bus.dmemREN    = r_ren;
  assign bus.dmemWEN    = r_wen;
  assign bus.dmemaddr   = r_addr;
  assign bus.dmemstore  = r_store;
  assign bus.load_data  = r_load;
  assign bus.mem_done   = r_mem_done;
  assign bus.halt_out   = r_halt;
  assign bus.timeout    = r_timeout;
  assign bus.access_cnt = r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_store    <= '0;
      r_load     <= '0;
      r_mem_done <= 1'b0;
      r_halt     <= 1'b0;
      r_timeout  <= 1'b0;
      r_flushed  <= 1'b0;
      r_wait     <= '0;
      r_cnt      <= '0;
    end else begin
      r_mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_addr    <= bus.addr_in;
            r_store   <= bus.store_in;
            // Read wins when both request bits are set.
            r_ren     <= bus.dren_in;
            r_wen     <= bus.dwen_in & ~bus.dren_in;
            r_flushed <= 1'b0;
            r_wait    <= '0;
            r_state   <= S_ACCESS;
          end else if (!w_op && bus.halt_in) begin
            r_halt  <= 1'b1;
            r_state <= S_HALTED;
          end
        end
        S_ACCESS: begin
          // Flush never aborts an in-flight dcache request; it only
          // suppresses the retirement side effects.
          if (bus.flush) begin
            r_flushed <= 1'b1;
          end
          if (bus.dhit) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= S_DONE;
            if (!w_discard) begin
              r_mem_done <= 1'b1;
              if (r_ren) begin
                r_load <= bus.dmemload;
              end
              if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end else if (r_wait == c_WAIT_LAST) begin
            // Watchdog only flags; the request keeps waiting for dhit.
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + c_WAIT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
